uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver for the audio control path: deserialises an asynchronous serial line into words of configurable width, with configurable stop bits and optional parity checking. It adds mid-bit majority-vote sampling, false-start rejection, framing/parity error reporting and a one-entry valid/ready output register with overrun detection. It sits between the board UART pin and the command/coefficient parser.

## Interface

Parameters:
- CLK_DIV, 434: clock cycles per bit. Legal range 8..65535.
- DATA_BITS, 8: data bits per frame. Legal range 5..9.
- STOP_BITS, 1: stop bits per frame. Legal values 1 or 2.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Used only when UART_RX_PARITY_EN is defined.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- uart_rx, input, 1: serial line. Asynchronous to clk; idles high.
- rx_data, output, DATA_BITS: received word, LSB = first bit on the line. Reset value 0.
- rx_valid, output, 1: rx_data and the flags hold an unconsumed frame. Reset value 0.
- rx_ready, input, 1: consumer accepts the frame when rx_valid && rx_ready.
- rx_frame_err, output, 1: any stop bit sampled 0. Qualified by rx_valid. Reset value 0.
- rx_parity_err, output, 1: parity mismatch. Qualified by rx_valid. Reset value 0.
- rx_overrun, output, 1: one-cycle pulse when a completed frame is dropped. Reset value 0.
- rx_busy, output, 1: high whenever the FSM is not in IDLE. Reset value 0.

## Operation

- uart_rx passes through a 2-flop synchroniser, reset to 1. All logic uses the synchronised value, rx_s.
- The bit counter bit_cnt runs 0..CLK_DIV-1 and wraps. HALF = CLK_DIV/2, integer division.
- Sample value = majority of rx_s captured at bit_cnt == HALF-2, HALF-1 and HALF. It is evaluated at HALF.
- FSM states:
  - IDLE: a falling edge on rx_s (previous 1, current 0) moves to START and clears bit_cnt to 0.
  - START: at HALF, sample 1 means a false start and returns to IDLE with nothing reported. Sample 0 continues. At CLK_DIV-1 go to DATA.
  - DATA: at HALF, shift the sample into the shift register, LSB first. After DATA_BITS bit periods go to PARITY when the macro is defined, otherwise go to STOP.
  - PARITY: at HALF, compare the sample against the XOR of the data bits, XORed with PARITY_ODD. A mismatch latches the parity error. At CLK_DIV-1 go to STOP.
  - STOP: at HALF of each stop bit, sample 0 latches the frame error. At HALF of the last stop bit, complete the frame and go to IDLE immediately. This gives half-bit resync margin for back-to-back frames.
- Frame completion:
  - If rx_valid is 0, or it is being consumed this cycle (rx_valid && rx_ready), load rx_data and both flags and set rx_valid.
  - Otherwise drop the frame, pulse rx_overrun, and leave the held frame untouched.
- Completion and handshake in the same cycle: the new frame loads and no overrun occurs.
- rx_valid clears on handshake unless a frame loads in the same cycle.
- Frames with a framing error are still delivered, with rx_frame_err set.
- Internal flags clear on entry to START.
- rst_n asserted mid-frame: all state returns to reset values immediately. The partial frame is discarded. Reception restarts at the next falling edge after release.

## Timing

- Input to FSM latency: 2 cycles of synchroniser plus 1 cycle of edge detect.
- Completion cycle is the edge-detect cycle + (1 + DATA_BITS + P) × CLK_DIV + (STOP_BITS − 1) × CLK_DIV + HALF, where P = 1 with parity and 0 without.
- rx_valid rises on the clock edge following the completion cycle.
- rx_valid, rx_data and the flags are registered. They remain stable while rx_valid && !rx_ready.
- rx_overrun is high for exactly one cycle per dropped frame.
- Tolerance: a line rate error of ±4% relative to CLK_DIV must be received correctly at 8N1.

## Configuration

- UART_RX_PARITY_EN defined:
  - The PARITY state exists; one parity bit is expected after the data bits.
  - rx_parity_err reports mismatches according to PARITY_ODD.
- UART_RX_PARITY_EN undefined:
  - No PARITY state; the frame is start + DATA_BITS + STOP_BITS.
  - rx_parity_err is tied to 0.
  - PARITY_ODD is ignored.

## Test plan

- Basic receive: CLK_DIV=16, 8N1, send 0xA5 with rx_ready=1 → rx_valid pulses one cycle, rx_data=0xA5, both error flags 0.
- Back-to-back frames: send 0x00 then 0xFF with no idle gap → two valid frames, 0x00 then 0xFF, no false start between them.
- Glitch and single-sample noise:
  - A 3-cycle low pulse on an idle line → rx_valid stays 0 and rx_busy returns to 0 within CLK_DIV cycles.
  - A one-cycle inverted glitch at HALF inside a data bit → correct data is still received.
- Framing error and overrun:
  - Send 0x3C with the stop bit forced to 0 → rx_data=0x3C, rx_frame_err=1.
  - Hold rx_ready=0 and send 0x11 then 0x22 → rx_data stays 0x11 and rx_overrun pulses once.
- Parity (macro defined, PARITY_ODD=0): send 0x07 with parity bit 0 → rx_parity_err=1. Send 0x07 with parity bit 1 → rx_parity_err=0.
- Reset mid-frame: assert rst_n low during DATA bit 3 → all outputs are 0 immediately. Release and send 0x5A → rx_data=0x5A with no residue from the aborted frame.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-vote sampling, false-start reject,
// one-entry valid/ready output. Define UART_RX_PARITY_EN for a parity bit.
module uart_rx_param #(
  parameter int CLK_DIV    = 434,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] HM1  = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] HM2  = CW'(CLK_DIV / 2 - 2);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [3:0] DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);

  if (CLK_DIV < 8 || CLK_DIV > 65535 ||
      DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1))
  begin : g_bad_param
    $error("uart_rx_param: illegal parameter");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_e;

  state_e               st_q;
  logic                 s1_q;
  logic                 rx_s_q;
  logic                 prev_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           idx_q;
  logic [1:0]           win_q;
  logic [DATA_BITS-1:0] sh_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 ferr_q;
  logic                 ferr_o_q;
  logic                 valid_q;
  logic                 ovr_q;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q;
  logic                 perr_o_q;
  logic                 par_exp_d;
`endif

  logic samp_d;
  logic fall_d;
  logic at_half;
  logic at_last;
  logic done_d;
  logic take_d;

  assign samp_d  = (win_q[0] & win_q[1]) |
                   (win_q[0] & rx_s_q) |
                   (win_q[1] & rx_s_q);
  assign fall_d  = prev_q & ~rx_s_q;
  assign at_half = (cnt_q == HALF);
  assign at_last = (cnt_q == LAST);
  assign done_d  = (st_q == STOP) && at_half &&
                   (idx_q == SLAST);
  assign take_d  = !valid_q || rx_ready;
`ifdef UART_RX_PARITY_EN
  assign par_exp_d = (^sh_q) ^ (PARITY_ODD != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b1;
      rx_s_q   <= 1'b1;
      prev_q   <= 1'b1;
      st_q     <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      win_q    <= 2'b11;
      sh_q     <= '0;
      data_q   <= '0;
      ferr_q   <= 1'b0;
      ferr_o_q <= 1'b0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q   <= 1'b0;
      perr_o_q <= 1'b0;
`endif
    end else begin
      s1_q   <= uart_rx;
      rx_s_q <= s1_q;
      prev_q <= rx_s_q;
      ovr_q  <= 1'b0;
      cnt_q  <= at_last ? '0 : cnt_q + CW'(1);
      if (cnt_q == HM2) win_q[0] <= rx_s_q;
      if (cnt_q == HM1) win_q[1] <= rx_s_q;
      if (valid_q && rx_ready) valid_q <= 1'b0;
      // a completing frame may reuse the slot being consumed now
      if (done_d) begin
        if (take_d) begin
          valid_q  <= 1'b1;
          data_q   <= sh_q;
          ferr_o_q <= ferr_q | ~samp_d;
`ifdef UART_RX_PARITY_EN
          perr_o_q <= perr_q;
`endif
        end else begin
          ovr_q <= 1'b1;
        end
      end
      unique case (st_q)
        IDLE: begin
          if (fall_d) begin
            st_q   <= START;
            cnt_q  <= '0;
            idx_q  <= '0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
          end
        end
        START: begin
          if (at_half && samp_d) st_q <= IDLE;
          else if (at_last) st_q <= DATA;
        end
        DATA: begin
          if (at_half)
            sh_q <= {samp_d, sh_q[DATA_BITS-1:1]};
          if (at_last) begin
            if (idx_q == DLAST) begin
              idx_q <= '0;
`ifdef UART_RX_PARITY_EN
              st_q  <= PARITY;
`else
              st_q  <= STOP;
`endif
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (at_half && (samp_d != par_exp_d))
            perr_q <= 1'b1;
          if (at_last) st_q <= STOP;
        end
`endif
        STOP: begin
          // leave at mid stop bit to resync on back-to-back frames
          if (at_half) begin
            if (!samp_d) ferr_q <= 1'b1;
            if (idx_q == SLAST) st_q <= IDLE;
            else idx_q <= idx_q + 4'd1;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_o_q;
  assign rx_overrun   = ovr_q;
  assign rx_busy      = (st_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = perr_o_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param at CLK_DIV=16, 8 data bits, 1 stop.
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_param;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_overrun;
  logic       rx_busy;

  uart_rx_param #(
    .CLK_DIV(DIV),
    .DATA_BITS(8),
    .STOP_BITS(1),
    .PARITY_ODD(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .uart_rx(uart_rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_overrun(rx_overrun),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rcv   = 0;
  int   n_ovr   = 0;
  bit   saw_busy = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d,
                              input logic fe,
                              input logic pe);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.pe = pe;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rx_overrun) n_ovr++;
    if (rx_busy) saw_busy = 1'b1;
    if (rst_n && rx_valid && rx_ready) begin
      exp_t e;
      n_rcv++;
      check("sb_pending", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("data", 32'(rx_data), 32'(e.d));
        check("frame_err", 32'(rx_frame_err), 32'(e.fe));
        check("parity_err", 32'(rx_parity_err), 32'(e.pe));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input bit glitch);
    for (int c = 0; c < DIV; c++) begin
      uart_rx = (glitch && c == DIV / 2) ? ~v : v;
      tick(1);
    end
  endtask

  task automatic send(input logic [7:0] d,
                      input logic stopv,
                      input int gbit);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], i == gbit);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip, 1'b0);
`endif
    drive_bit(stopv, 1'b0);
    uart_rx = 1'b1;
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (sb.size() == 0) break;
      tick(1);
    end
    check("drain", 32'(sb.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    rst_n    = 1'b0;
    uart_rx  = 1'b1;
    rx_ready = 1'b1;
    tick(4);
    check("rst_data", 32'(rx_data), 0);
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_ferr", 32'(rx_frame_err), 0);
    check("rst_perr", 32'(rx_parity_err), 0);
    check("rst_ovr", 32'(rx_overrun), 0);
    check("rst_busy", 32'(rx_busy), 0);
    rst_n = 1'b1;
    tick(20);

    sb.push_back(mk(8'hA5, 1'b0, 1'b0));
    send(8'hA5, 1'b1, -1);
    wait_drain(4 * DIV);
    tick(DIV);

    r0 = n_rcv;
    sb.push_back(mk(8'h00, 1'b0, 1'b0));
    sb.push_back(mk(8'hFF, 1'b0, 1'b0));
    send(8'h00, 1'b1, -1);
    send(8'hFF, 1'b1, -1);
    wait_drain(4 * DIV);
    tick(2 * DIV);
    check("b2b_count", 32'(n_rcv - r0), 2);

    r0 = n_rcv;
    saw_busy = 1'b0;
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(DIV);
    check("glitch_busy_seen", 32'(saw_busy), 1);
    check("glitch_busy", 32'(rx_busy), 0);
    check("glitch_valid", 32'(rx_valid), 0);
    tick(2 * DIV);
    check("glitch_count", 32'(n_rcv - r0), 0);

    sb.push_back(mk(8'h96, 1'b0, 1'b0));
    send(8'h96, 1'b1, 2);
    wait_drain(4 * DIV);
    sb.push_back(mk(8'h69, 1'b0, 1'b0));
    send(8'h69, 1'b1, 5);
    wait_drain(4 * DIV);
    tick(DIV);

    sb.push_back(mk(8'h3C, 1'b1, 1'b0));
    send(8'h3C, 1'b0, -1);
    wait_drain(4 * DIV);
    tick(2 * DIV);

    r0 = n_ovr;
    rx_ready = 1'b0;
    sb.push_back(mk(8'h11, 1'b0, 1'b0));
    send(8'h11, 1'b1, -1);
    tick(DIV);
    send(8'h22, 1'b1, -1);
    tick(DIV);
    check("ovr_pulses", 32'(n_ovr - r0), 1);
    check("ovr_hold_valid", 32'(rx_valid), 1);
    check("ovr_hold_data", 32'(rx_data), 32'h11);
    rx_ready = 1'b1;
    wait_drain(8);
    tick(DIV);

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    sb.push_back(mk(8'h07, 1'b0, 1'b1));
    send(8'h07, 1'b1, -1);
    wait_drain(4 * DIV);
    par_flip = 1'b0;
    sb.push_back(mk(8'h07, 1'b0, 1'b0));
    send(8'h07, 1'b1, -1);
    wait_drain(4 * DIV);
    tick(DIV);
`endif

    rx_ready = 1'b0;
    send(8'hC3, 1'b1, -1);
    tick(DIV);
    check("hold_valid", 32'(rx_valid), 1);
    check("hold_data", 32'(rx_data), 32'hC3);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b0);
    uart_rx = 1'b0;
    tick(DIV / 2);
    check("mid_busy", 32'(rx_busy), 1);
    #2;
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    #1;
    check("mrst_data", 32'(rx_data), 0);
    check("mrst_valid", 32'(rx_valid), 0);
    check("mrst_ferr", 32'(rx_frame_err), 0);
    check("mrst_perr", 32'(rx_parity_err), 0);
    check("mrst_ovr", 32'(rx_overrun), 0);
    check("mrst_busy", 32'(rx_busy), 0);
    tick(3);
    rst_n    = 1'b1;
    rx_ready = 1'b1;
    tick(DIV);
    r0 = n_rcv;
    sb.push_back(mk(8'h5A, 1'b0, 1'b0));
    send(8'h5A, 1'b1, -1);
    wait_drain(4 * DIV);
    tick(2 * DIV);
    check("post_rst_count", 32'(n_rcv - r0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
